// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, EX redirect flushes, fixed-latency memory waits, forwarding selects.
// Stall/flush/forward outputs are combinational (zero latency); a memory wait holds the whole pipeline for MEM_LAT cycles.
module hazard_control_unit #(
  parameter int         MEM_LAT = 2,
  parameter logic [1:0] WB_LOAD = 2'b01,
  parameter int         CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_rs1_addr_decode,
  input  logic [4:0]       i_rs2_addr_decode,
  input  logic [4:0]       i_rs1_addr_execute,
  input  logic [4:0]       i_rs2_addr_execute,
  input  logic [4:0]       i_rd_addr_execute,
  input  logic             i_rd_wren_execute,
  input  logic [1:0]       i_wb_sel_execute,
  input  logic             i_pc_taken_execute,
  input  logic [4:0]       i_rd_addr_memory,
  input  logic             i_rd_wren_memory,
  input  logic             i_mem_req_memory,
  input  logic [4:0]       i_rd_addr_writeback,
  input  logic             i_rd_wren_writeback,
  output logic             o_stall_fetch,
  output logic             o_stall_decode,
  output logic             o_stall_execute,
  output logic             o_stall_memory,
  output logic             o_flush_decode,
  output logic             o_flush_execute,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam bit             LAT_EN  = (MEM_LAT != 0);
  localparam logic [3:0]     LAT_M1  = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             mem_stall;
  logic             load_ex;
  logic             load_use;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // rs2 is compared even for formats without rs2; a spurious bubble is cheaper than a missed hazard.
  always_comb begin
    load_ex  = i_rd_wren_execute && (i_wb_sel_execute == WB_LOAD) && (i_rd_addr_execute != 5'd0);
    load_use = load_ex && ((i_rs1_addr_decode == i_rd_addr_execute) ||
                           (i_rs2_addr_decode == i_rd_addr_execute));
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       mem_wren, input logic [4:0] mem_rd,
                                         input logic       wb_wren,  input logic [4:0] wb_rd);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_wren && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_wren && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    o_fwd_a_sel = FWD_RF;
    o_fwd_b_sel = FWD_RF;
    if (i_reset) begin
      o_fwd_a_sel = fwd_sel(i_rs1_addr_execute, i_rd_wren_memory, i_rd_addr_memory,
                            i_rd_wren_writeback, i_rd_addr_writeback);
      o_fwd_b_sel = fwd_sel(i_rs2_addr_execute, i_rd_wren_memory, i_rd_addr_memory,
                            i_rd_wren_writeback, i_rd_addr_writeback);
    end
  end

  // Memory-wait FSM: state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory-wait FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_mem_req_memory && LAT_EN) begin
          state_d = S_WAIT;
          cnt_d   = LAT_M1;
        end
      end
      S_WAIT: begin
        // The cnt==0 cycle is the release cycle; a request still asserted there is the same access.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Memory-wait FSM: output
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE:  mem_stall = i_mem_req_memory && LAT_EN;
      S_WAIT:  mem_stall = (cnt_q != 4'd0);
      default: mem_stall = 1'b0;
    endcase
  end

  // Held redirects and load-use hazards reappear after release because the stalled stages keep their inputs.
  always_comb begin
    o_stall_fetch   = 1'b0;
    o_stall_decode  = 1'b0;
    o_stall_execute = 1'b0;
    o_stall_memory  = 1'b0;
    o_flush_decode  = 1'b0;
    o_flush_execute = 1'b0;
    if (!i_reset) begin
      o_stall_fetch = 1'b0;
    end else if (mem_stall) begin
      o_stall_fetch   = 1'b1;
      o_stall_decode  = 1'b1;
      o_stall_execute = 1'b1;
      o_stall_memory  = 1'b1;
    end else if (i_pc_taken_execute) begin
      o_flush_decode  = 1'b1;
      o_flush_execute = 1'b1;
    end else if (load_use) begin
      o_stall_fetch   = 1'b1;
      o_stall_decode  = 1'b1;
      o_flush_execute = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_stall_fetch && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (o_flush_decode && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (MEM_LAT=2) with an expected-output queue and a counter model.
module tb_hazard_control_unit;

  localparam int CNT_W = 32;

  logic             i_clk;
  logic             i_reset;
  logic [4:0]       i_rs1_addr_decode, i_rs2_addr_decode;
  logic [4:0]       i_rs1_addr_execute, i_rs2_addr_execute, i_rd_addr_execute;
  logic             i_rd_wren_execute;
  logic [1:0]       i_wb_sel_execute;
  logic             i_pc_taken_execute;
  logic [4:0]       i_rd_addr_memory;
  logic             i_rd_wren_memory;
  logic             i_mem_req_memory;
  logic [4:0]       i_rd_addr_writeback;
  logic             i_rd_wren_writeback;
  logic             o_stall_fetch, o_stall_decode, o_stall_execute, o_stall_memory;
  logic             o_flush_decode, o_flush_execute;
  logic [1:0]       o_fwd_a_sel, o_fwd_b_sel;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

  hazard_control_unit #(.MEM_LAT(2), .WB_LOAD(2'b01), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rs1_addr_decode(i_rs1_addr_decode), .i_rs2_addr_decode(i_rs2_addr_decode),
    .i_rs1_addr_execute(i_rs1_addr_execute), .i_rs2_addr_execute(i_rs2_addr_execute),
    .i_rd_addr_execute(i_rd_addr_execute), .i_rd_wren_execute(i_rd_wren_execute),
    .i_wb_sel_execute(i_wb_sel_execute), .i_pc_taken_execute(i_pc_taken_execute),
    .i_rd_addr_memory(i_rd_addr_memory), .i_rd_wren_memory(i_rd_wren_memory),
    .i_mem_req_memory(i_mem_req_memory),
    .i_rd_addr_writeback(i_rd_addr_writeback), .i_rd_wren_writeback(i_rd_wren_writeback),
    .o_stall_fetch(o_stall_fetch), .o_stall_decode(o_stall_decode),
    .o_stall_execute(o_stall_execute), .o_stall_memory(o_stall_memory),
    .o_flush_decode(o_flush_decode), .o_flush_execute(o_flush_execute),
    .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected vector: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_a[1:0], fwd_b[1:0]}
  localparam logic [9:0] E_IDLE  = 10'b0000_00_00_00;
  localparam logic [9:0] E_LU    = 10'b1100_01_00_00;
  localparam logic [9:0] E_MEM   = 10'b1111_00_00_00;
  localparam logic [9:0] E_FLUSH = 10'b0000_11_00_00;

  logic [9:0]       sb[$];
  int               n_assert = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_scnt = '0;
  logic [CNT_W-1:0] exp_fcnt = '0;

  task automatic idle_inputs();
    i_rs1_addr_decode   = 5'd0; i_rs2_addr_decode  = 5'd0;
    i_rs1_addr_execute  = 5'd0; i_rs2_addr_execute = 5'd0;
    i_rd_addr_execute   = 5'd0; i_rd_wren_execute  = 1'b0;
    i_wb_sel_execute    = 2'b00; i_pc_taken_execute = 1'b0;
    i_rd_addr_memory    = 5'd0; i_rd_wren_memory   = 1'b0;
    i_mem_req_memory    = 1'b0;
    i_rd_addr_writeback = 5'd0; i_rd_wren_writeback = 1'b0;
  endtask

  task automatic set_load_ex(input logic [4:0] rd);
    i_rd_addr_execute = rd;
    i_rd_wren_execute = 1'b1;
    i_wb_sel_execute  = 2'b01;
  endtask

  // Counters are compared before the edge, so they reflect all previously checked cycles.
  task automatic step(input string tag, input logic [9:0] exp);
    logic [9:0] e;
    logic [9:0] obs;
    sb.push_back(exp);
    #2;
    obs = {o_stall_fetch, o_stall_decode, o_stall_execute, o_stall_memory,
           o_flush_decode, o_flush_execute, o_fwd_a_sel, o_fwd_b_sel};
    n_assert++;
    assert (o_stall_cnt === exp_scnt) else begin
      n_fail++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, o_stall_cnt, exp_scnt);
    end
    n_assert++;
    assert (o_flush_cnt === exp_fcnt) else begin
      n_fail++;
      $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, o_flush_cnt, exp_fcnt);
    end
    e = sb.pop_front();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs, e);
    end
    if (i_reset && e[9]) exp_scnt = exp_scnt + 1;
    if (i_reset && e[5]) exp_fcnt = exp_fcnt + 1;
  endtask

  initial begin
    i_reset = 1'b0;
    idle_inputs();
    // Hazard-looking inputs while in reset must not leak to the outputs.
    i_pc_taken_execute = 1'b1;
    i_mem_req_memory   = 1'b1;
    i_rd_wren_memory = 1'b1; i_rd_addr_memory = 5'd4; i_rs1_addr_execute = 5'd4;
    step("reset_state", E_IDLE);
    @(negedge i_clk);
    step("reset_held", E_IDLE);

    @(negedge i_clk); i_reset = 1'b1; idle_inputs();
    step("after_reset", E_IDLE);

    // Load-use on rs2, then bubble, then writeback forwarding.
    @(negedge i_clk); idle_inputs(); set_load_ex(5'd5); i_rs2_addr_decode = 5'd5;
    step("load_use_rs2", E_LU);
    @(negedge i_clk); idle_inputs(); i_rs2_addr_decode = 5'd5;
    i_rd_addr_memory = 5'd5; i_rd_wren_memory = 1'b1;
    step("after_bubble", E_IDLE);
    @(negedge i_clk); idle_inputs(); i_rs2_addr_execute = 5'd5;
    i_rd_addr_writeback = 5'd5; i_rd_wren_writeback = 1'b1;
    step("fwd_b_wb", 10'b0000_00_00_10);

    // Load-use on rs1; a non-load with a match must not stall.
    @(negedge i_clk); idle_inputs(); set_load_ex(5'd9); i_rs1_addr_decode = 5'd9;
    step("load_use_rs1", E_LU);
    @(negedge i_clk); idle_inputs(); set_load_ex(5'd9); i_wb_sel_execute = 2'b00;
    i_rs1_addr_decode = 5'd9;
    step("alu_no_stall", E_IDLE);
    @(negedge i_clk); idle_inputs(); set_load_ex(5'd0);
    step("load_x0_no_stall", E_IDLE);

    // Forwarding priority and x0 suppression.
    @(negedge i_clk); idle_inputs(); i_rs1_addr_execute = 5'd3;
    i_rd_addr_memory = 5'd3; i_rd_wren_memory = 1'b1;
    i_rd_addr_writeback = 5'd3; i_rd_wren_writeback = 1'b1;
    step("fwd_a_mem_prio", 10'b0000_00_01_00);
    @(negedge i_clk); i_rd_wren_memory = 1'b0; i_rs2_addr_execute = 5'd3;
    step("fwd_ab_wb", 10'b0000_00_10_10);
    @(negedge i_clk); idle_inputs(); i_rs2_addr_execute = 5'd6;
    i_rd_addr_memory = 5'd6; i_rd_wren_memory = 1'b1;
    step("fwd_b_mem", 10'b0000_00_00_01);
    @(negedge i_clk); idle_inputs();
    i_rd_addr_memory = 5'd0; i_rd_wren_memory = 1'b1;
    i_rd_addr_writeback = 5'd0; i_rd_wren_writeback = 1'b1;
    step("fwd_x0", E_IDLE);

    // Memory access: two stall cycles then release with the request still high.
    @(negedge i_clk); idle_inputs(); i_mem_req_memory = 1'b1;
    step("mem_stall_1", E_MEM);
    @(negedge i_clk);
    step("mem_stall_2", E_MEM);
    @(negedge i_clk);
    step("mem_release", E_IDLE);
    @(negedge i_clk); i_mem_req_memory = 1'b0;
    step("mem_idle", E_IDLE);

    // Back-to-back accesses each pay the full penalty.
    @(negedge i_clk); i_mem_req_memory = 1'b1;
    step("b2b_a_1", E_MEM);
    @(negedge i_clk); step("b2b_a_2", E_MEM);
    @(negedge i_clk); step("b2b_a_rel", E_IDLE);
    @(negedge i_clk); step("b2b_b_1", E_MEM);
    @(negedge i_clk); step("b2b_b_2", E_MEM);
    @(negedge i_clk); step("b2b_b_rel", E_IDLE);

    // Redirect held during the memory stall, applied in the release cycle.
    @(negedge i_clk); idle_inputs(); i_mem_req_memory = 1'b1; i_pc_taken_execute = 1'b1;
    step("redir_stall_1", E_MEM);
    @(negedge i_clk); step("redir_stall_2", E_MEM);
    @(negedge i_clk); step("redir_release", E_FLUSH);
    @(negedge i_clk); idle_inputs();
    step("redir_done", E_IDLE);

    // Redirect wins over load-use.
    @(negedge i_clk); idle_inputs(); set_load_ex(5'd7); i_rs1_addr_decode = 5'd7;
    i_pc_taken_execute = 1'b1;
    step("branch_over_lu", E_FLUSH);

    // Reset in the middle of a wait.
    @(negedge i_clk); idle_inputs(); i_mem_req_memory = 1'b1;
    step("rst_wait_1", E_MEM);
    @(negedge i_clk); i_reset = 1'b0;
    exp_scnt = '0; exp_fcnt = '0;
    step("rst_mid_wait", E_IDLE);
    @(negedge i_clk); i_reset = 1'b1;
    step("post_rst_1", E_MEM);
    @(negedge i_clk); step("post_rst_2", E_MEM);
    @(negedge i_clk); step("post_rst_rel", E_IDLE);
    @(negedge i_clk); idle_inputs();
    step("final_idle", E_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
